ifft_iter: RTL and testbench



---
 rtl/fft_pkg.sv | 68 ++++++
 rtl/ifft_bfly.sv | 50 +++++
 rtl/ifft_iter.sv | 146 ++++++++++++++
 tb/tb_ifft_iter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared FFT definitions: complex sample type, index helpers and the twiddle ROM
// (forward-FFT convention W = cos - j*sin, stored at 14 fraction bits).
package fft_pkg;

    localparam int unsigned CPLX_RN      = 16;
    localparam int unsigned TW_FRAC      = 14;
    localparam int unsigned TW_MAX_SIZE  = 128;

    typedef struct packed {
        logic signed [CPLX_RN-1:0] re;
        logic signed [CPLX_RN-1:0] im;
    } cplx_t;

    function automatic int unsigned log2_int(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic int unsigned bitrev(input int unsigned idx, input int unsigned bits);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i < bits) r = (r << 1) | ((idx >> i) & 32'd1);
        end
        return r;
    endfunction

    // cos(2*pi*i/128) * 2^14 for the first quarter wave, i = 0..32
    function automatic int tw_quarter(input int unsigned i);
        int v;
        case (i)
            0:  v = 16384;  1:  v = 16364;  2:  v = 16305;  3:  v = 16207;
            4:  v = 16069;  5:  v = 15893;  6:  v = 15679;  7:  v = 15426;
            8:  v = 15137;  9:  v = 14811;  10: v = 14449;  11: v = 14053;
            12: v = 13623;  13: v = 13160;  14: v = 12665;  15: v = 12140;
            16: v = 11585;  17: v = 11003;  18: v = 10394;  19: v = 9760;
            20: v = 9102;   21: v = 8423;   22: v = 7723;   23: v = 7005;
            24: v = 6270;   25: v = 5520;   26: v = 4756;   27: v = 3981;
            28: v = 3196;   29: v = 2404;   30: v = 1606;   31: v = 804;
            default: v = 0;
        endcase
        return v;
    endfunction

    function automatic int tw_rom_re(input int unsigned t, input int unsigned size);
        int unsigned i;
        i = t * (TW_MAX_SIZE / size);
        if (i <= 32) return tw_quarter(i);
        return -tw_quarter(64 - i);
    endfunction

    function automatic int tw_rom_im(input int unsigned t, input int unsigned size);
        int unsigned i;
        i = t * (TW_MAX_SIZE / size);
        if (i <= 32) return -tw_quarter(32 - i);
        return -tw_quarter(i - 32);
    endfunction

    function automatic int tw_scale(input int v, input int unsigned frac);
        if (frac >= TW_FRAC) return v <<< (frac - TW_FRAC);
        return v >>> (TW_FRAC - frac);
    endfunction

endpackage

// File: rtl/ifft_bfly.sv
// Combinational radix-2 DIT butterfly with 1/2 scaling; conj selects the
// inverse (conjugated) twiddle.
module ifft_bfly
    import fft_pkg::*;
#(
    parameter int unsigned RN   = 16,
    parameter int unsigned FRAC = 14
) (
    input  logic                 conj,
    input  logic signed [RN-1:0] a_re,
    input  logic signed [RN-1:0] a_im,
    input  logic signed [RN-1:0] b_re,
    input  logic signed [RN-1:0] b_im,
    input  logic signed [RN-1:0] w_re,
    input  logic signed [RN-1:0] w_im,
    output logic signed [RN-1:0] top_re,
    output logic signed [RN-1:0] top_im,
    output logic signed [RN-1:0] bot_re,
    output logic signed [RN-1:0] bot_im
);

    localparam int unsigned PW = 2 * RN + 2;

    logic signed [PW-1:0] br, bi, wr, wi, prod_re, prod_im;
    logic signed [RN:0]   ar, ai, pr, pi;
    logic signed [RN:0]   st_re, st_im, sb_re, sb_im;

    always_comb begin
        br = PW'(b_re);
        bi = PW'(b_im);
        wr = PW'(w_re);
        wi = conj ? -PW'(w_im) : PW'(w_im);
        prod_re = (br * wr - bi * wi) >>> FRAC;
        prod_im = (br * wi + bi * wr) >>> FRAC;
        // product is floored at full width, then wrapped back to RN bits
        pr = (RN+1)'(RN'(prod_re));
        pi = (RN+1)'(RN'(prod_im));
        ar = (RN+1)'(a_re);
        ai = (RN+1)'(a_im);
        st_re = ar + pr;
        st_im = ai + pi;
        sb_re = ar - pr;
        sb_im = ai - pi;
        top_re = RN'(st_re >>> 1);
        top_im = RN'(st_im >>> 1);
        bot_re = RN'(sb_re >>> 1);
        bot_im = RN'(sb_im >>> 1);
    end

endmodule

// File: rtl/ifft_iter.sv
// Iterative in-place radix-2 DIT inverse FFT: bit-reversed load, one butterfly
// per clock, natural-order drain with ready/valid backpressure.
module ifft_iter
    import fft_pkg::*;
#(
    parameter int unsigned SIZE = 16,
    parameter int unsigned RN   = 16,
    parameter int unsigned FRAC = 14
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [RN-1:0] in_re,
    input  logic [RN-1:0] in_im,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [RN-1:0] out_re,
    output logic [RN-1:0] out_im,
    output logic          out_last,
    output logic          busy
);

    localparam int unsigned L  = log2_int(SIZE);
    localparam int unsigned AW = L;
    localparam int unsigned SW = (L > 1) ? $clog2(L) : 1;
    localparam int unsigned BW = (L > 1) ? L - 1 : 1;

    typedef enum logic [1:0] {LOAD, COMPUTE, DRAIN} state_t;

    state_t state, state_nxt;

    logic [AW-1:0] cnt;
    logic [SW-1:0] stage;
    logic [BW-1:0] bfly;
    logic          last_bfly;

    logic signed [RN-1:0] mem_re [SIZE];
    logic signed [RN-1:0] mem_im [SIZE];

    int unsigned   a_s, a_b, a_half, a_pos, a_top;
    logic [AW-1:0] top_addr, bot_addr, tw_idx, load_addr;

    logic signed [RN-1:0] w_re, w_im;
    logic signed [RN-1:0] y_top_re, y_top_im, y_bot_re, y_bot_im;

    assign last_bfly = (stage == SW'(L - 1)) && (bfly == BW'(SIZE / 2 - 1));
    assign load_addr = AW'(bitrev(32'(cnt), L));

    always_comb begin
        a_s      = 32'(stage);
        a_b      = 32'(bfly);
        a_half   = 32'd1 << a_s;
        a_pos    = a_b & (a_half - 1);
        a_top    = ((a_b >> a_s) << (a_s + 1)) + a_pos;
        top_addr = AW'(a_top);
        bot_addr = AW'(a_top + a_half);
        tw_idx   = AW'(a_pos << (L - 1 - a_s));
        w_re     = RN'(tw_scale(tw_rom_re(32'(tw_idx), SIZE), FRAC));
        w_im     = RN'(tw_scale(tw_rom_im(32'(tw_idx), SIZE), FRAC));
    end

    ifft_bfly #(.RN(RN), .FRAC(FRAC)) u_bfly (
        .conj   (1'b1),
        .a_re   (mem_re[top_addr]),
        .a_im   (mem_im[top_addr]),
        .b_re   (mem_re[bot_addr]),
        .b_im   (mem_im[bot_addr]),
        .w_re   (w_re),
        .w_im   (w_im),
        .top_re (y_top_re),
        .top_im (y_top_im),
        .bot_re (y_bot_re),
        .bot_im (y_bot_im)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= LOAD;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    if (in_valid && cnt == AW'(SIZE - 1)) state_nxt = COMPUTE;
            COMPUTE: if (last_bfly) state_nxt = DRAIN;
            DRAIN:   if (out_ready && cnt == AW'(SIZE - 1)) state_nxt = LOAD;
            default: state_nxt = LOAD;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        busy      = 1'b0;
        out_re    = mem_re[cnt];
        out_im    = mem_im[cnt];
        case (state)
            LOAD:    in_ready = 1'b1;
            COMPUTE: busy = 1'b1;
            DRAIN: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_last  = (cnt == AW'(SIZE - 1));
            end
            default: ;
        endcase
    end

    // cnt serves as load index k and drain index n; both wrap to 0 at SIZE
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            stage <= '0;
            bfly  <= '0;
        end else begin
            case (state)
                LOAD: if (in_valid) cnt <= cnt + 1'b1;
                COMPUTE: begin
                    if (bfly == BW'(SIZE / 2 - 1)) begin
                        bfly  <= '0;
                        stage <= last_bfly ? '0 : stage + 1'b1;
                    end else begin
                        bfly <= bfly + 1'b1;
                    end
                end
                DRAIN: if (out_ready) cnt <= cnt + 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && state == LOAD && in_valid) begin
            mem_re[load_addr] <= in_re;
            mem_im[load_addr] <= in_im;
        end else if (!reset && state == COMPUTE) begin
            mem_re[top_addr] <= y_top_re;
            mem_im[top_addr] <= y_top_im;
            mem_re[bot_addr] <= y_bot_re;
            mem_im[bot_addr] <= y_bot_im;
        end
    end

endmodule

// File: tb/tb_ifft_iter.sv
// Self-checking bench for ifft_iter: table of spectra against a floating-point
// inverse DFT, scoreboard on the output stream, plus reset/backpressure corners.
module tb_ifft_iter;
    import fft_pkg::*;

    localparam int unsigned SIZE = 16;
    localparam int unsigned RN   = 16;
    localparam int unsigned FRAC = 14;
    localparam real         PI   = 3.14159265358979323846;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic signed [RN-1:0] in_re = '0;
    logic signed [RN-1:0] in_im = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic signed [RN-1:0] out_re, out_im;
    logic                 out_last;
    logic                 busy;

    ifft_iter #(.SIZE(SIZE), .RN(RN), .FRAC(FRAC)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int stall_mode = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int re;
        int im;
        bit last;
        int tol;
        int n;
    } exp_t;

    typedef struct {
        string name;
        int    kind;   // 0 flat, 1 single bin, 2 random
        int    bin;
        int    amp;
        int    tol;
        bit    gaps;
        bit    stall;
        bit    hold;
    } vec_t;

    exp_t  sb[$];
    cplx_t xin [SIZE];
    int    er  [SIZE];
    int    ei  [SIZE];

    task automatic chk(input string name, input bit ok, input int act, input int req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic build_input(input vec_t v);
        for (int k = 0; k < SIZE; k++) begin
            case (v.kind)
                0: begin xin[k].re = 16'(v.amp); xin[k].im = '0; end
                1: begin xin[k].re = (k == v.bin) ? 16'(v.amp) : '0; xin[k].im = '0; end
                default: begin
                    xin[k].re = 16'(int'($urandom_range(0, 2 * v.amp)) - v.amp);
                    xin[k].im = 16'(int'($urandom_range(0, 2 * v.amp)) - v.amp);
                end
            endcase
        end
    endtask

    // x[n] = (1/N) * sum_k X[k] * e^{+j*2*pi*k*n/N}
    task automatic compute_ref();
        for (int n = 0; n < SIZE; n++) begin
            real sr, si, th, xr, xi;
            sr = 0.0;
            si = 0.0;
            for (int k = 0; k < SIZE; k++) begin
                th = 2.0 * PI * real'(k * n) / real'(SIZE);
                xr = real'(int'(xin[k].re));
                xi = real'(int'(xin[k].im));
                sr = sr + xr * $cos(th) - xi * $sin(th);
                si = si + xr * $sin(th) + xi * $cos(th);
            end
            er[n] = int'(sr / real'(SIZE));
            ei[n] = int'(si / real'(SIZE));
        end
    endtask

    task automatic load_frame(input bit gaps, input bit push, input int tol, output int t_last);
        int guard;
        t_last = cyc;
        if (push)
            for (int n = 0; n < SIZE; n++)
                sb.push_back('{re: er[n], im: ei[n], last: (n == SIZE - 1), tol: tol, n: n});
        for (int k = 0; k < SIZE; k++) begin
            in_re    = xin[k].re;
            in_im    = xin[k].im;
            in_valid = 1'b1;
            guard    = 0;
            while (!in_ready && guard < 200) begin
                @(posedge clk); #1;
                guard++;
            end
            if (!in_ready) begin
                chk("load_timeout", 1'b0, guard, 0);
                in_valid = 1'b0;
                return;
            end
            t_last = cyc;
            @(posedge clk); #1;
            if (gaps && k < SIZE - 1) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b0;
    endtask

    // Output-side scoreboard and stream-protocol checks
    exp_t        e;
    logic        prev_stall = 1'b0;
    logic        prev_final = 1'b0;
    int          hold_re, hold_im, hold_last;

    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
            prev_final = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", out_valid, int'(out_valid), 1);
                chk("stall_re", int'(out_re) == hold_re, int'(out_re), hold_re);
                chk("stall_im", int'(out_im) == hold_im, int'(out_im), hold_im);
                chk("stall_last", int'(out_last) == hold_last, int'(out_last), hold_last);
            end
            if (prev_final) begin
                chk("drain_end_valid", !out_valid, int'(out_valid), 0);
                chk("drain_end_ready", in_ready, int'(in_ready), 1);
            end
            prev_stall = out_valid && !out_ready;
            prev_final = out_valid && out_ready && out_last;
            hold_re    = int'(out_re);
            hold_im    = int'(out_im);
            hold_last  = int'(out_last);
            if (out_valid) begin
                chk("in_ready_in_drain", !in_ready, int'(in_ready), 0);
                if (out_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_output", 1'b0, int'(out_re), 0);
                    end else begin
                        e = sb.pop_front();
                        chk($sformatf("out_re[%0d]", e.n), iabs(int'(out_re) - e.re) <= e.tol, int'(out_re), e.re);
                        chk($sformatf("out_im[%0d]", e.n), iabs(int'(out_im) - e.im) <= e.tol, int'(out_im), e.im);
                        chk($sformatf("out_last[%0d]", e.n), out_last == e.last, int'(out_last), int'(e.last));
                    end
                end
            end
        end
    end

    always begin
        @(posedge clk); #1;
        out_ready = (stall_mode == 0) ? 1'b1 : ($urandom_range(0, 99) < 30);
    end

    task automatic run_frame(input vec_t v);
        int t_last;
        int c;
        load_frame(v.gaps, 1'b1, v.tol, t_last);
        chk("busy_after_load", busy, int'(busy), 1);
        stall_mode = v.stall ? 1 : 0;
        if (v.hold) begin
            in_valid = 1'b1;
            in_re    = 16'sh7fff;
            in_im    = -16'sh7fff;
        end
        c = 0;
        while (!out_valid && c < 200) begin
            @(posedge clk); #1;
            c++;
        end
        chk({v.name, "_latency"}, cyc - t_last == 33, cyc - t_last, 33);
        c = 0;
        while (c < 1000) begin
            if (in_ready) begin
                in_valid = 1'b0;
                if (sb.size() == 0) break;
            end
            @(posedge clk); #1;
            c++;
        end
        if (c >= 1000) begin
            chk({v.name, "_drain_timeout"}, 1'b0, sb.size(), 0);
            sb.delete();
        end
        in_valid   = 1'b0;
        stall_mode = 0;
        @(posedge clk); #1;
    endtask

    vec_t vecs[7];

    initial begin
        int t_last;
        vec_t dc;
        vecs[0] = '{name: "flat",       kind: 0, bin: 0, amp: 8192,  tol: 1, gaps: 0, stall: 0, hold: 0};
        vecs[1] = '{name: "dc",         kind: 1, bin: 0, amp: 16384, tol: 0, gaps: 0, stall: 0, hold: 0};
        vecs[2] = '{name: "tone",       kind: 1, bin: 1, amp: 16384, tol: 2, gaps: 0, stall: 0, hold: 0};
        vecs[3] = '{name: "tone_stall", kind: 1, bin: 1, amp: 16384, tol: 2, gaps: 0, stall: 1, hold: 0};
        vecs[4] = '{name: "flat_gaps",  kind: 0, bin: 0, amp: 8192,  tol: 1, gaps: 1, stall: 0, hold: 1};
        vecs[5] = '{name: "dc_after",   kind: 1, bin: 0, amp: 16384, tol: 0, gaps: 0, stall: 0, hold: 0};
        vecs[6] = '{name: "random",     kind: 2, bin: 0, amp: 6000,  tol: 4, gaps: 1, stall: 1, hold: 0};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", in_ready, int'(in_ready), 1);
        chk("reset_out_valid", !out_valid, int'(out_valid), 0);
        chk("reset_out_last", !out_last, int'(out_last), 0);
        chk("reset_busy", !busy, int'(busy), 0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("post_reset_in_ready", in_ready, int'(in_ready), 1);

        for (int i = 0; i < 7; i++) begin
            build_input(vecs[i]);
            compute_ref();
            run_frame(vecs[i]);
        end

        // Reset at compute cycle 10 abandons the frame without output
        dc = vecs[1];
        build_input(dc);
        compute_ref();
        load_frame(1'b0, 1'b0, 0, t_last);
        repeat (9) begin
            @(posedge clk); #1;
        end
        chk("mid_busy", busy, int'(busy), 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_in_ready", in_ready, int'(in_ready), 1);
        chk("abort_out_valid", !out_valid, int'(out_valid), 0);
        chk("abort_busy", !busy, int'(busy), 0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("abort_no_output", !out_valid && in_ready, int'(out_valid), 0);
        dc.name = "dc_post_reset";
        run_frame(dc);

        chk("scoreboard_empty", sb.size() == 0, sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got cycle %0d, expected completion", cyc);
        $fatal(1, "watchdog");
    end

endmodule
